// File: rtl/solve_ntru_mac_pipe_if.sv
// Sample/result bus of the solve_NTRU multiply-accumulate pipe.
// The master drives samples and receives results; the slave is the pipe itself.
interface solve_ntru_mac_pipe_if #(
    parameter int unsigned A_WIDTH = 12,
    parameter int unsigned B_WIDTH = 8,
    parameter int unsigned P_WIDTH = 12
);
    logic               in_valid;
    logic [A_WIDTH-1:0] din0;
    logic [B_WIDTH-1:0] din1;
    logic               acc_en;
    logic               acc_clr;
    logic               out_valid;
    logic [P_WIDTH-1:0] dout;
    logic               ovf;

    modport master (
        output in_valid, din0, din1, acc_en, acc_clr,
        input  out_valid, dout, ovf
    );

    modport slave (
        input  in_valid, din0, din1, acc_en, acc_clr,
        output out_valid, dout, ovf
    );
endinterface

// File: rtl/solve_ntru_mac_pipe.sv
// Pipelined signed multiplier / multiply-accumulate for the solve_NTRU datapath.
// Stage 1 registers the sample, stage 2 the full product, stages 3..NUM_STAGE-1 delay it,
// and stage NUM_STAGE accumulates and converts to a wrapped or saturated P_WIDTH result.
// ce=0 freezes every register; reset (synchronous, active-low) wins over ce.
module solve_ntru_mac_pipe #(
    parameter int unsigned A_WIDTH   = 12,
    parameter int unsigned B_WIDTH   = 8,
    parameter int unsigned P_WIDTH   = 12,
    parameter int unsigned ACC_WIDTH = A_WIDTH + B_WIDTH + 4,
    parameter int unsigned NUM_STAGE = 4,
    parameter int unsigned B_SIGNED  = 0,
    parameter int unsigned SAT_MODE  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    solve_ntru_mac_pipe_if.slave bus
);
    localparam int unsigned PROD_WIDTH = A_WIDTH + B_WIDTH + 1;
    // Product register plus NUM_STAGE-3 delay registers
    localparam int DEPTH = NUM_STAGE - 2;
    localparam int LAST  = DEPTH - 1;

    // Stage 1
    logic [A_WIDTH-1:0] a_q;
    logic [B_WIDTH-1:0] b_q;
    logic               v1_q, en1_q, clr1_q;

    // Stages 2..NUM_STAGE-1
    logic signed [PROD_WIDTH-1:0] prod_q [DEPTH];
    logic [DEPTH-1:0]             vp_q, enp_q, clrp_q;

    // Stage NUM_STAGE
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        out_valid_q, ovf_q;
    logic [P_WIDTH-1:0]          dout_q, dout_d;

    logic signed [PROD_WIDTH-1:0] a_ext, b_ext, prod_d;
    logic signed [ACC_WIDTH-1:0]  p_ext, r_d;
    logic [ACC_WIDTH-P_WIDTH:0]   r_upper;
    logic                         b_msb, fits;

    // Full-width product; extending b by its own MSB or zero picks signed/unsigned din1
    always_comb begin
        b_msb  = (B_SIGNED != 0) ? b_q[B_WIDTH-1] : 1'b0;
        a_ext  = {{(B_WIDTH + 1){a_q[A_WIDTH-1]}}, a_q};
        b_ext  = {{(A_WIDTH + 1){b_msb}}, b_q};
        prod_d = a_ext * b_ext;
    end

    // Input register and product/delay chain
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q    <= '0;
            b_q    <= '0;
            v1_q   <= 1'b0;
            en1_q  <= 1'b0;
            clr1_q <= 1'b0;
            vp_q   <= '0;
            enp_q  <= '0;
            clrp_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                prod_q[i] <= '0;
            end
        end else if (ce) begin
            a_q       <= bus.din0;
            b_q       <= bus.din1;
            v1_q      <= bus.in_valid;
            en1_q     <= bus.acc_en;
            clr1_q    <= bus.acc_clr;
            prod_q[0] <= prod_d;
            vp_q[0]   <= v1_q;
            enp_q[0]  <= en1_q;
            clrp_q[0] <= clr1_q;
            for (int i = 1; i < DEPTH; i++) begin
                prod_q[i] <= prod_q[i-1];
                vp_q[i]   <= vp_q[i-1];
                enp_q[i]  <= enp_q[i-1];
                clrp_q[i] <= clrp_q[i-1];
            end
        end
    end

    // Accumulate, range check and output conversion for the sample in the last slot
    always_comb begin
        p_ext   = ACC_WIDTH'(prod_q[LAST]);
        r_d     = (enp_q[LAST] && !clrp_q[LAST]) ? acc_q + p_ext : p_ext;
        // r fits in P_WIDTH signed iff all bits from P_WIDTH-1 upward agree
        r_upper = r_d[ACC_WIDTH-1:P_WIDTH-1];
        fits    = (&r_upper) || !(|r_upper);
        if ((SAT_MODE != 0) && !fits) begin
            dout_d = r_d[ACC_WIDTH-1] ? {1'b1, {(P_WIDTH - 1){1'b0}}}
                                      : {1'b0, {(P_WIDTH - 1){1'b1}}};
        end else begin
            dout_d = r_d[P_WIDTH-1:0];
        end
        acc_d = acc_q;
        if (vp_q[LAST] && enp_q[LAST]) begin
            acc_d = r_d;
        end
    end

    // Output stage; bubbles drop out_valid but leave dout/ovf untouched
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else if (ce) begin
            acc_q       <= acc_d;
            out_valid_q <= vp_q[LAST];
            if (vp_q[LAST]) begin
                dout_q <= dout_d;
                ovf_q  <= !fits;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_solve_ntru_mac_pipe.sv
// Directed bench for solve_ntru_mac_pipe: three instances (wrap/unsigned, saturating,
// signed din1) share one stimulus stream and are checked against hand-computed values.
module tb_solve_ntru_mac_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic [11:0] din0;
    logic [7:0]  din1;
    logic        acc_en;
    logic        acc_clr;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    solve_ntru_mac_pipe_if #(.A_WIDTH(12), .B_WIDTH(8), .P_WIDTH(12)) bus_a ();
    solve_ntru_mac_pipe_if #(.A_WIDTH(12), .B_WIDTH(8), .P_WIDTH(12)) bus_s ();
    solve_ntru_mac_pipe_if #(.A_WIDTH(12), .B_WIDTH(8), .P_WIDTH(12)) bus_b ();

    assign bus_a.in_valid = in_valid;
    assign bus_a.din0     = din0;
    assign bus_a.din1     = din1;
    assign bus_a.acc_en   = acc_en;
    assign bus_a.acc_clr  = acc_clr;
    assign bus_s.in_valid = in_valid;
    assign bus_s.din0     = din0;
    assign bus_s.din1     = din1;
    assign bus_s.acc_en   = acc_en;
    assign bus_s.acc_clr  = acc_clr;
    assign bus_b.in_valid = in_valid;
    assign bus_b.din0     = din0;
    assign bus_b.din1     = din1;
    assign bus_b.acc_en   = acc_en;
    assign bus_b.acc_clr  = acc_clr;

    solve_ntru_mac_pipe #(.B_SIGNED(0), .SAT_MODE(0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .bus   (bus_a.slave)
    );

    solve_ntru_mac_pipe #(.B_SIGNED(0), .SAT_MODE(1)) dut_s (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .bus   (bus_s.slave)
    );

    solve_ntru_mac_pipe #(.B_SIGNED(1), .SAT_MODE(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .bus   (bus_b.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [11:0] a, input logic [7:0] b, input logic en,
                         input logic clr);
        in_valid = 1'b1;
        din0     = a;
        din1     = b;
        acc_en   = en;
        acc_clr  = clr;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        acc_en   = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        ce    = 1'b1;
        din0  = '0;
        din1  = '0;
        idle();
        tick();
        tick();
        check("rst_valid", 32'(bus_a.out_valid), 32'h0);
        check("rst_dout", 32'(bus_a.dout), 32'h0);
        check("rst_ovf", 32'(bus_a.ovf), 32'h0);
        reset = 1'b1;

        // Single multiply: -3 * 200 = -600
        drive(12'hFFD, 8'hC8, 1'b0, 1'b0);
        tick();
        idle();
        for (int c = 1; c < 4; c++) begin
            check("t1_early_valid", 32'(bus_a.out_valid), 32'h0);
            tick();
        end
        check("t1_valid", 32'(bus_a.out_valid), 32'h1);
        check("t1_dout", 32'(bus_a.dout), 32'hDA8);
        check("t1_ovf", 32'(bus_a.ovf), 32'h0);
        check("t1_sat_dout", 32'(bus_s.dout), 32'hDA8);
        check("t1_bs_dout", 32'(bus_b.dout), 32'h0A8);  // -3 * -56
        tick();
        check("t1_after_valid", 32'(bus_a.out_valid), 32'h0);
        check("t1_after_hold", 32'(bus_a.dout), 32'hDA8);

        // Positive overflow: 2047 * 255 = 521985
        drive(12'h7FF, 8'hFF, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        tick();
        check("t2_valid", 32'(bus_a.out_valid), 32'h1);
        check("t2_wrap_dout", 32'(bus_a.dout), 32'h701);
        check("t2_wrap_ovf", 32'(bus_a.ovf), 32'h1);
        check("t2_sat_dout", 32'(bus_s.dout), 32'h7FF);
        check("t2_sat_ovf", 32'(bus_s.ovf), 32'h1);
        check("t2_bs_dout", 32'(bus_b.dout), 32'h801);  // 2047 * -1
        check("t2_bs_ovf", 32'(bus_b.ovf), 32'h0);

        // Negative overflow: -2048 * 200 = -409600
        drive(12'h800, 8'hC8, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        tick();
        check("t2n_wrap_dout", 32'(bus_a.dout), 32'h000);
        check("t2n_wrap_ovf", 32'(bus_a.ovf), 32'h1);
        check("t2n_sat_dout", 32'(bus_s.dout), 32'h800);
        check("t2n_sat_ovf", 32'(bus_s.ovf), 32'h1);
        check("t2n_bs_ovf", 32'(bus_b.ovf), 32'h1);  // -2048 * -56 = 114688

        // Back-to-back accumulation: 30, 30-20=10, 10+14=24
        drive(12'h00A, 8'h03, 1'b1, 1'b1);
        tick();
        drive(12'hFFB, 8'h04, 1'b1, 1'b0);
        tick();
        drive(12'h007, 8'h02, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        check("t3_s0_valid", 32'(bus_a.out_valid), 32'h1);
        check("t3_s0_dout", 32'(bus_a.dout), 32'h01E);
        tick();
        check("t3_s1_valid", 32'(bus_a.out_valid), 32'h1);
        check("t3_s1_dout", 32'(bus_a.dout), 32'h00A);
        tick();
        check("t3_s2_valid", 32'(bus_a.out_valid), 32'h1);
        check("t3_s2_dout", 32'(bus_a.dout), 32'h018);
        check("t3_s2_sat", 32'(bus_s.dout), 32'h018);
        tick();
        check("t3_end_valid", 32'(bus_a.out_valid), 32'h0);

        // Stall: 6*5=30 and -7*3=-21 in flight while ce=0 for 3 cycles
        drive(12'h006, 8'h05, 1'b0, 1'b0);
        tick();
        drive(12'hFF9, 8'h03, 1'b0, 1'b0);
        tick();
        idle();
        ce = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("t4_stall_valid", 32'(bus_a.out_valid), 32'h0);
            tick();
        end
        ce = 1'b1;
        check("t4_c5_valid", 32'(bus_a.out_valid), 32'h0);
        tick();
        check("t4_c6_valid", 32'(bus_a.out_valid), 32'h0);
        tick();
        check("t4_s0_valid", 32'(bus_a.out_valid), 32'h1);
        check("t4_s0_dout", 32'(bus_a.dout), 32'h01E);
        ce = 1'b0;
        tick();
        check("t4_hold_valid", 32'(bus_a.out_valid), 32'h1);
        check("t4_hold_dout", 32'(bus_a.dout), 32'h01E);
        ce = 1'b1;
        tick();
        check("t4_s1_valid", 32'(bus_a.out_valid), 32'h1);
        check("t4_s1_dout", 32'(bus_a.dout), 32'hFEB);
        tick();
        check("t4_end_valid", 32'(bus_a.out_valid), 32'h0);
        check("t4_end_hold", 32'(bus_a.dout), 32'hFEB);

        // Reset with three samples in flight; accumulator (24) must be cleared too
        drive(12'h064, 8'h02, 1'b0, 1'b0);
        tick();
        drive(12'h003, 8'h03, 1'b0, 1'b0);
        tick();
        drive(12'h005, 8'h05, 1'b0, 1'b0);
        tick();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t5_rst_dout", 32'(bus_a.dout), 32'h0);
        for (int c = 0; c < 6; c++) begin
            check("t5_flush_valid", 32'(bus_a.out_valid), 32'h0);
            tick();
        end
        drive(12'h009, 8'h07, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        tick();
        tick();
        check("t5_acc_valid", 32'(bus_a.out_valid), 32'h1);
        check("t5_acc_dout", 32'(bus_a.dout), 32'h03F);

        // Signed din1: -4 * 0xFE
        drive(12'hFFC, 8'hFE, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        tick();
        check("t6_bs_valid", 32'(bus_b.out_valid), 32'h1);
        check("t6_bs_dout", 32'(bus_b.dout), 32'h008);
        check("t6_bs_ovf", 32'(bus_b.ovf), 32'h0);
        check("t6_us_dout", 32'(bus_a.dout), 32'hC08);  // -4 * 254 = -1016

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
